fpu_seq: RTL and testbench
==========================

FPU_SEQ -- requirements
Module: fpu_seq

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: cycles allowed in WAIT_END plus ACK before abort (used only with FPU_SEQ_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 arst  in  1  reset; synchronous, active-high.
REQ-004 req_valid  in  1  command request.
REQ-005 req_ready  out  1  sequencer accepts request this cycle.
REQ-006 req_op  in  8  FPU opcode byte, passed through unmodified.
REQ-007 req_a  in  32  operand A.
REQ-008 req_b  in  32  operand B.
REQ-009 rsp_valid  out  1  result available.
REQ-010 rsp_ready  in  1  consumer takes result.
REQ-011 rsp_result  out  32  FPU result word.
REQ-012 rsp_err  out  1  command aborted by timeout.
REQ-013 fpu_data_o  out  8  byte to FPU databus_in.
REQ-014 fpu_data_i  in  8  byte from FPU databus_out.
REQ-015 fpu_addr  out  4  FPU register address.
REQ-016 fpu_cs / fpu_rd / fpu_wr  out  1 each  FPU strobes, active-low.
REQ-017 fpu_end_ack  out  1  acknowledge to FPU, active-high.
REQ-018 fpu_cmd_end  in  1  FPU end-of-command.
REQ-019 fpu_busy  in  1  FPU operation in progress.

Function
REQ-020 States SHALL be IDLE, WR_SETUP, WR_STROBE, WR_HOLD, WAIT_END, RD_SETUP, RD_STROBE, RD_HOLD, ACK, RESP.
REQ-021 req_ready SHALL be 1 only in IDLE with fpu_busy=0 and fpu_cmd_end=0; handshake = req_valid&req_ready; req_a, req_b and req_op SHALL be latched at handshake.
REQ-022 Write sequence SHALL be 9 bytes: addr 0..3 = A[7:0]..A[31:24], addr 4..7 = B LSB-first, addr 8 = opcode.
REQ-023 Each write byte SHALL take 3 cycles: WR_SETUP (cs=0, addr and data valid, wr=1), WR_STROBE (wr=0), WR_HOLD (wr=1, addr and data held); cs SHALL stay 0 between bytes; write phase = 27 cycles.
REQ-024 After the addr-8 WR_HOLD, fpu_cs SHALL go 1 and the state SHALL be WAIT_END until fpu_cmd_end=1.
REQ-025 Read sequence SHALL be addr 9..C into result[7:0]..[31:24]; per byte RD_SETUP (cs=0, addr valid, rd=1), RD_STROBE 2 cycles (rd=0, fpu_data_i sampled on the 2nd cycle's edge), RD_HOLD (rd=1); read phase = 16 cycles.
REQ-026 ACK SHALL drive fpu_end_ack=1, cs=1 until fpu_cmd_end samples 0, then deassert end_ack and enter RESP.
REQ-027 RESP SHALL hold rsp_valid=1 with rsp_result and rsp_err stable until rsp_ready=1, then return to IDLE on the next cycle.
REQ-028 req_valid in any non-IDLE state SHALL be ignored; fpu_data_o SHALL be 0 whenever fpu_wr phase is inactive outside a write byte.
REQ-029 fpu_rd and fpu_wr SHALL never both be 0; strobes SHALL be registered outputs (no glitches).
REQ-030 An fpu_cmd_end pulse before the opcode write is complete SHALL be ignored.

Reset
REQ-031 arst=1 at any state SHALL, on that edge, force IDLE, fpu_cs=fpu_rd=fpu_wr=1, fpu_end_ack=0, fpu_addr=0, fpu_data_o=0, rsp_valid=0, rsp_err=0, rsp_result=0, timer=0.
REQ-032 Reset mid-command SHALL drop the in-flight command with no response; the FPU itself is not reset by this block.

Configuration
REQ-033 Macro FPU_SEQ_TIMEOUT_EN defined: a counter SHALL run in WAIT_END and ACK; on reaching TIMEOUT_CYCLES the sequencer SHALL deassert fpu_end_ack, set rsp_err=1 and rsp_result=0, and enter RESP.
REQ-034 Macro undefined: no counter, rsp_err tied 0, WAIT_END and ACK wait indefinitely.

Verification
REQ-035 A=0x3F800000, B=0x40000000, op=0x00, FPU model returns 0x40400000 -> bus writes 00,00,80,3F,00,00,00,40,00 at addr 0..8, reads 9..C, rsp_result=0x40400000, rsp_err=0.
REQ-036 FPU model asserts cmd_end 5 cycles after opcode write -> rsp_valid rises exactly 5+16+ack cycles later; write phase measured as 27 cycles.
REQ-037 rsp_ready held 0 for 10 cycles in RESP -> rsp_valid and rsp_result stable, req_ready=0, no bus activity.
REQ-038 arst pulsed during 3rd write byte -> next cycle all strobes inactive, IDLE, a following request completes normally.
REQ-039 fpu_busy=1 or stale fpu_cmd_end=1 in IDLE with req_valid=1 -> req_ready=0, no cs activity until both clear.
REQ-040 FPU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=64, FPU never asserts cmd_end -> rsp_valid=1, rsp_err=1, rsp_result=0 after 64 cycles in WAIT_END.

Source files
------------

// File: rtl/fpu_seq.sv
// fpu_seq: byte-wide FPU bus sequencer (9 writes, wait cmd_end, 4 reads, ack); FPU_SEQ_TIMEOUT_EN adds an abort timer
module fpu_seq #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  output logic [7:0]  fpu_data_o,
  input  logic [7:0]  fpu_data_i,
  output logic [3:0]  fpu_addr,
  output logic        fpu_cs,
  output logic        fpu_rd,
  output logic        fpu_wr,
  output logic        fpu_end_ack,
  input  logic        fpu_cmd_end,
  input  logic        fpu_busy
);
  typedef enum logic [3:0] {
    IDLE, WR_SETUP, WR_STROBE, WR_HOLD, WAIT_END, RD_SETUP, RD_STROBE, RD_HOLD, ACK, RESP
  } state_t;
  state_t state, nxt;
  logic [3:0] idx, idx_nxt;
  logic rd2, rd2_nxt;
  logic [71:0] wbuf;
  logic hs, timeout, abort, bus_nxt;
  assign req_ready = state == IDLE && !fpu_busy && !fpu_cmd_end;
  assign hs = req_valid && req_ready;
  assign fpu_addr = idx;
  assign fpu_data_o = state inside {WR_SETUP, WR_STROBE, WR_HOLD} ? wbuf[7:0] : 8'h00;
  assign abort = timeout && (state == WAIT_END ? !fpu_cmd_end : state == ACK && fpu_cmd_end);
  assign bus_nxt = nxt inside {WR_SETUP, WR_STROBE, WR_HOLD, RD_SETUP, RD_STROBE, RD_HOLD};
`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;
  logic err;
  assign timeout = timer == TW'(TIMEOUT_CYCLES - 1);
  assign rsp_err = err;
  // timer keeps its count across the read burst so WAIT_END and ACK share one budget
  always_ff @(posedge clk)
    if (arst || hs) begin
      timer <= '0;
      err <= 1'b0;
    end else begin
      if (state == WAIT_END || state == ACK) timer <= timer + 1'b1;
      if (abort) err <= 1'b1;
    end
`else
  assign timeout = TIMEOUT_CYCLES < 0;
  assign rsp_err = 1'b0;
`endif
  always_comb begin
    nxt = state;
    idx_nxt = idx;
    rd2_nxt = rd2;
    case (state)
      IDLE: if (hs) begin
        nxt = WR_SETUP;
        idx_nxt = 4'd0;
      end
      WR_SETUP: nxt = WR_STROBE;
      WR_STROBE: nxt = WR_HOLD;
      WR_HOLD: if (idx == 4'd8) nxt = WAIT_END;
        else begin
          nxt = WR_SETUP;
          idx_nxt = idx + 4'd1;
        end
      WAIT_END: if (fpu_cmd_end) begin
        nxt = RD_SETUP;
        idx_nxt = 4'd9;
      end else if (abort) nxt = RESP;
      RD_SETUP: begin
        nxt = RD_STROBE;
        rd2_nxt = 1'b0;
      end
      RD_STROBE: if (rd2) nxt = RD_HOLD;
        else rd2_nxt = 1'b1;
      RD_HOLD: if (idx == 4'd12) nxt = ACK;
        else begin
          nxt = RD_SETUP;
          idx_nxt = idx + 4'd1;
        end
      ACK: if (!fpu_cmd_end || abort) nxt = RESP;
      RESP: if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // strobes are registered from the next state so they never glitch
  always_ff @(posedge clk)
    if (arst) begin
      state <= IDLE;
      idx <= '0;
      rd2 <= 1'b0;
      wbuf <= '0;
      rsp_result <= '0;
      fpu_cs <= 1'b1;
      fpu_rd <= 1'b1;
      fpu_wr <= 1'b1;
      fpu_end_ack <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state <= nxt;
      idx <= idx_nxt;
      rd2 <= rd2_nxt;
      fpu_cs <= !bus_nxt;
      fpu_wr <= nxt != WR_STROBE;
      fpu_rd <= nxt != RD_STROBE;
      fpu_end_ack <= nxt == ACK;
      rsp_valid <= nxt == RESP;
      if (hs) wbuf <= {req_op, req_b, req_a};
      else if (state == WR_HOLD) wbuf <= wbuf >> 8;
      if (abort) rsp_result <= '0;
      else if (state == RD_STROBE && rd2) rsp_result <= {fpu_data_i, rsp_result[31:8]};
    end
endmodule

// File: tb/tb_fpu_seq.sv
// tb_fpu_seq: randomized self-checking bench for fpu_seq with a cycle-level FPU bus model
module tb_fpu_seq;
  logic clk = 0, arst = 1, req_valid = 0, rsp_ready = 0, fpu_cmd_end = 0, fpu_busy = 0;
  logic req_ready, rsp_valid, rsp_err, fpu_cs, fpu_rd, fpu_wr, fpu_end_ack;
  logic [7:0] req_op = 0, fpu_data_o, fpu_data_i = 0;
  logic [31:0] req_a = 0, req_b = 0, rsp_result;
  logic [3:0] fpu_addr;
  int vectors = 0, miscompares = 0;
  logic [31:0] fpu_res = 0;
  int cmd_delay = 5, cnt = 0;
  logic ce = 0, force_end = 0;
  int cyc = 0, prot_err = 0, t_end = -1, t_valid = -1, n_ack = 0, t_last_wr = -1;
  logic [14:0] trace[$];

  fpu_seq #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .arst(arst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .fpu_data_o(fpu_data_o), .fpu_data_i(fpu_data_i),
    .fpu_addr(fpu_addr), .fpu_cs(fpu_cs), .fpu_rd(fpu_rd), .fpu_wr(fpu_wr),
    .fpu_end_ack(fpu_end_ack), .fpu_cmd_end(fpu_cmd_end), .fpu_busy(fpu_busy)
  );

  initial forever #5 clk = ~clk;

  // FPU model: raises cmd_end cmd_delay cycles after the opcode strobe, drops it on end_ack
  initial forever begin
    @(posedge clk); #1;
    if (!fpu_wr && fpu_addr == 4'd8) cnt = cmd_delay;
    else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) ce = 1;
    end
    if (fpu_end_ack) ce = 0;
    fpu_cmd_end = ce | force_end;
    fpu_data_i = (!fpu_rd && fpu_addr >= 9 && fpu_addr <= 12) ? fpu_res[8*(fpu_addr-9) +: 8] : 8'($urandom);
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (fpu_cs === 1'b0) trace.push_back({fpu_cs, fpu_wr, fpu_rd, fpu_addr, fpu_data_o});
    if (fpu_cs === 1'b0 && fpu_addr <= 8) t_last_wr = cyc;
    if (fpu_cmd_end === 1'b1 && t_end < 0) t_end = cyc;
    if (rsp_valid === 1'b1 && t_valid < 0) t_valid = cyc;
    if (fpu_end_ack === 1'b1) n_ack++;
    if ((fpu_rd === 1'b0 && fpu_wr === 1'b0) || ((fpu_cs === 1'b1 || fpu_addr > 8) && fpu_data_o !== 8'h00) ||
        (fpu_end_ack === 1'b1 && fpu_cs === 1'b0)) prot_err++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op, output bit ok);
    int n = 0;
    req_a = a; req_b = b; req_op = op; req_valid = 1;
    while (req_ready !== 1'b1 && n < 200) begin tick(); n++; end
    ok = req_ready === 1'b1;
    trace.delete(); t_end = -1; t_valid = -1; n_ack = 0; t_last_wr = -1;
    tick();
    req_valid = 0; req_a = $urandom; req_b = $urandom; req_op = 8'($urandom);
  endtask

  task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op, input logic [31:0] res,
                         input int delay, input int hold, input int early, output int lat);
    bit ok;
    int n, bad;
    logic [14:0] exp[$];
    logic [71:0] w;
    logic [31:0] exp_res;
    logic exp_err;
    lat = -1;
    fpu_res = res; cmd_delay = delay; rsp_ready = 0;
    issue(a, b, op, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL handshake: req_ready=%b, want 1 within 200 cycles", req_ready);
      return;
    end
    if (early >= 0) begin
      n = 0;
      while (!(fpu_cs === 1'b0 && fpu_addr == 4'(early)) && n < 100) begin tick(); n++; end
      force_end = 1; tick(); force_end = 0;
    end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 3000) begin tick(); n++; end
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rsp_timeout: rsp_valid=%b, want 1 within 3000 cycles", rsp_valid);
      return;
    end
    exp_err = delay < 0;
    exp_res = exp_err ? 32'h0 : res;
    vectors++;
    if ({rsp_err, rsp_result} !== {exp_err, exp_res}) begin
      miscompares++;
      $display("FAIL response: err=%b result=%h, want err=%b result=%h", rsp_err, rsp_result, exp_err, exp_res);
    end
    w = {op, b, a};
    for (int k = 0; k < 9; k++) begin
      exp.push_back({1'b0, 1'b1, 1'b1, 4'(k), w[8*k +: 8]});
      exp.push_back({1'b0, 1'b0, 1'b1, 4'(k), w[8*k +: 8]});
      exp.push_back({1'b0, 1'b1, 1'b1, 4'(k), w[8*k +: 8]});
    end
    if (!exp_err) for (int k = 9; k < 13; k++) begin
      exp.push_back({1'b0, 1'b1, 1'b1, 4'(k), 8'h00});
      exp.push_back({1'b0, 1'b1, 1'b0, 4'(k), 8'h00});
      exp.push_back({1'b0, 1'b1, 1'b0, 4'(k), 8'h00});
      exp.push_back({1'b0, 1'b1, 1'b1, 4'(k), 8'h00});
    end
    bad = -1;
    if (trace.size() == exp.size()) foreach (exp[i]) if (bad < 0 && trace[i] !== exp[i]) bad = i;
    vectors++;
    if (trace.size() != exp.size() || bad >= 0) begin
      miscompares++;
      $display("FAIL bus_trace: %0d cs-low cycles, first diff idx %0d got %h; want %0d cycles, entry %h",
               trace.size(), bad, bad >= 0 ? trace[bad] : 15'h0, exp.size(), bad >= 0 ? exp[bad] : 15'h0);
    end
    lat = t_valid - t_end;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1; req_a = $urandom;
      vectors++;
      if ({rsp_valid, rsp_err, rsp_result, req_ready, fpu_cs, fpu_wr, fpu_rd} !== {1'b1, exp_err, exp_res, 4'b0111}) begin
        miscompares++;
        $display("FAIL resp_stall: valid=%b err=%b result=%h ready=%b cs=%b wr=%b rd=%b, want 1 %b %h 0 1 1 1",
                 rsp_valid, rsp_err, rsp_result, req_ready, fpu_cs, fpu_wr, fpu_rd, exp_err, exp_res);
      end
      tick();
    end
    req_valid = 0; rsp_ready = 1;
    tick();
    rsp_ready = 0;
    vectors++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL resp_release: valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
    end
    vectors++;
    if (prot_err !== 0) begin
      miscompares++;
      $display("FAIL bus_protocol: %0d violating cycles, want 0", prot_err);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if ({fpu_cs, fpu_rd, fpu_wr, fpu_end_ack, fpu_addr, fpu_data_o, rsp_valid, rsp_err, rsp_result} !==
        {4'b1110, 4'h0, 8'h00, 2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL %s: cs=%b rd=%b wr=%b ack=%b addr=%h data=%h valid=%b err=%b result=%h, want 1 1 1 0 0 00 0 0 0",
               name, fpu_cs, fpu_rd, fpu_wr, fpu_end_ack, fpu_addr, fpu_data_o, rsp_valid, rsp_err, rsp_result);
    end
  endtask

  task automatic test_reset();
    arst = 1;
    tick(); tick();
    check_reset_outputs("reset_state");
    arst = 0;
    tick();
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: req_ready=%b, want 1", req_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    run_cmd(32'h3F800000, 32'h40000000, 8'h00, 32'h40400000, 5, 0, -1, lat);
  endtask

  task automatic test_timing();
    int lat, nw;
    run_cmd($urandom, $urandom, 8'($urandom), $urandom, 5, 0, -1, lat);
    nw = 0;
    foreach (trace[i]) if (trace[i][11:8] <= 4'd8) nw++;
    vectors++;
    if (nw !== 27) begin
      miscompares++;
      $display("FAIL write_phase: %0d cycles, want 27", nw);
    end
    vectors++;
    if (n_ack !== 1 || lat !== 16 + n_ack + 1) begin
      miscompares++;
      $display("FAIL latency: cmd_end->rsp_valid %0d cycles with %0d ack cycles, want 18 with 1", lat, n_ack);
    end
  endtask

  task automatic test_stall();
    int lat;
    run_cmd($urandom, $urandom, 8'($urandom), $urandom, 3, 10, -1, lat);
  endtask

  task automatic test_reset_mid();
    bit ok, bad;
    int n, lat;
    fpu_res = $urandom; cmd_delay = 5;
    issue($urandom, $urandom, 8'($urandom), ok);
    n = 0;
    while (!(fpu_cs === 1'b0 && fpu_addr == 4'd2) && n < 100) begin tick(); n++; end
    vectors++;
    if (!ok || fpu_cs !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_start: ok=%b cs=%b, want 1 0", ok, fpu_cs);
    end
    arst = 1;
    tick();
    check_reset_outputs("reset_mid_state");
    arst = 0;
    tick();
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_idle: req_ready=%b, want 1", req_ready);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid !== 1'b0 || fpu_cs !== 1'b1) bad = 1;
      tick();
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL reset_mid_drop: response or bus activity after reset, want none");
    end
    run_cmd($urandom, $urandom, 8'($urandom), $urandom, 4, 0, -1, lat);
  endtask

  task automatic test_gate();
    int lat;
    fpu_busy = 1; req_valid = 1; req_a = $urandom;
    tick();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({req_ready, fpu_cs} !== 2'b01) begin
        miscompares++;
        $display("FAIL gate_busy: req_ready=%b cs=%b, want 0 1", req_ready, fpu_cs);
      end
      tick();
    end
    force_end = 1;
    tick();
    fpu_busy = 0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({req_ready, fpu_cs} !== 2'b01) begin
        miscompares++;
        $display("FAIL gate_stale_end: req_ready=%b cs=%b, want 0 1", req_ready, fpu_cs);
      end
      tick();
    end
    force_end = 0; req_valid = 0;
    run_cmd($urandom, $urandom, 8'($urandom), $urandom, 6, 0, -1, lat);
  endtask

  task automatic test_random();
    int lat;
    for (int i = 0; i < 6; i++)
      run_cmd($urandom, $urandom, 8'($urandom), $urandom, $urandom_range(1, 20), $urandom_range(0, 3),
              (i % 2) ? int'($urandom_range(0, 7)) : -1, lat);
  endtask

`ifdef FPU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    run_cmd($urandom, $urandom, 8'($urandom), $urandom, -1, 2, -1, lat);
    vectors++;
    if (t_valid - t_last_wr !== 65) begin
      miscompares++;
      $display("FAIL timeout_len: %0d cycles from last write to rsp_valid, want 65", t_valid - t_last_wr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_timing();
    test_stall();
    test_reset_mid();
    test_gate();
    test_random();
`ifdef FPU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
